// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with registered sync and blanking outputs.
// Define VGA_TICK_DIV_EN to add a divide-by-4 pixel prescaler (100 MHz clk_d in, 25 MHz pixels).
module vga_sync_gen #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33
) (
  input  logic       clk_d,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       p_tick,
  output logic       frame_tick
);

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_VIS);
  localparam logic [9:0] V_VIS_END    = 10'(V_VIS);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

  logic [9:0] h_count_q, h_count_d;
  logic [9:0] v_count_q, v_count_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;

`ifdef VGA_TICK_DIV_EN
  logic [1:0] prescale_q, prescale_d;

  always_comb begin
    prescale_d = prescale_q + 2'd1;
  end

  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      prescale_q <= 2'd0;
    end else begin
      prescale_q <= prescale_d;
    end
  end

  assign p_tick = (prescale_q == 2'd3);
`else
  assign p_tick = 1'b1;
`endif

  // Sync and blanking are decoded from the next counts so the registered
  // outputs line up with pixel_x/pixel_y in the same cycle.
  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    if (p_tick) begin
      if (h_count_q == H_LAST) begin
        h_count_d = 10'd0;
        if (v_count_q == V_LAST) begin
          v_count_d = 10'd0;
        end else begin
          v_count_d = v_count_q + 10'd1;
        end
      end else begin
        h_count_d = h_count_q + 10'd1;
      end
    end

    hsync_d    = !((h_count_d >= H_SYNC_FIRST) && (h_count_d <= H_SYNC_LAST));
    vsync_d    = !((v_count_d >= V_SYNC_FIRST) && (v_count_d <= V_SYNC_LAST));
    video_on_d = (h_count_d < H_VIS_END) && (v_count_d < V_VIS_END);
  end

  // Reset values describe pixel (0,0): visible, both syncs inactive.
  always_ff @(posedge clk_d or posedge reset) begin
    if (reset) begin
      h_count_q  <= 10'd0;
      v_count_q  <= 10'd0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b1;
    end else begin
      h_count_q  <= h_count_d;
      v_count_q  <= v_count_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign pixel_x    = h_count_q;
  assign pixel_y    = v_count_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign frame_tick = p_tick && (h_count_q == H_LAST) && (v_count_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: one default-timing instance and one
// scaled-down instance checked every cycle against a frame-position model.
module tb_vga_sync_gen;

`ifdef VGA_TICK_DIV_EN
  localparam int DIV = 4;
`else
  localparam int DIV = 1;
`endif

  typedef struct packed {
    int hv; int hfp; int hs; int hbp;
    int vv; int vfp; int vs; int vbp;
  } timing_t;

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       p_tick;
    logic       frame_tick;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  localparam timing_t T0 = '{hv:640, hfp:16, hs:96, hbp:48, vv:480, vfp:10, vs:2, vbp:33};
  localparam timing_t T1 = '{hv:64, hfp:4, hs:8, hbp:4, vv:48, vfp:3, vs:2, vbp:5};
  localparam int FRAME1 = 80 * 58;

  logic clk_d = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   n = 0;

  logic       d0_hsync, d0_vsync, d0_von, d0_pt, d0_ft;
  logic [9:0] d0_x, d0_y;
  logic       d1_hsync, d1_vsync, d1_von, d1_pt, d1_ft;
  logic [9:0] d1_x, d1_y;

  always #5 clk_d = ~clk_d;

  vga_sync_gen dut0 (
    .clk_d(clk_d), .reset(reset), .hsync(d0_hsync), .vsync(d0_vsync),
    .video_on(d0_von), .pixel_x(d0_x), .pixel_y(d0_y), .p_tick(d0_pt),
    .frame_tick(d0_ft)
  );

  vga_sync_gen #(
    .H_VIS(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_VIS(48), .V_FP(3), .V_SYNC(2), .V_BP(5)
  ) dut1 (
    .clk_d(clk_d), .reset(reset), .hsync(d1_hsync), .vsync(d1_vsync),
    .video_on(d1_von), .pixel_x(d1_x), .pixel_y(d1_y), .p_tick(d1_pt),
    .frame_tick(d1_ft)
  );

  // n = clk_d edges since reset was released; everything else follows from it.
  always @(posedge clk_d or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  function automatic exp_t model(input timing_t t, input int cyc);
    exp_t e;
    int ht, vt, idx, x, y;
    ht = t.hv + t.hfp + t.hs + t.hbp;
    vt = t.vv + t.vfp + t.vs + t.vbp;
    idx = (cyc / DIV) % (ht * vt);
    x = idx % ht;
    y = idx / ht;
    e.x = 10'(x);
    e.y = 10'(y);
    e.p_tick = ((cyc % DIV) == DIV - 1);
    e.hsync = !((x >= t.hv + t.hfp) && (x < t.hv + t.hfp + t.hs));
    e.vsync = !((y >= t.vv + t.vfp) && (y < t.vv + t.vfp + t.vs));
    e.video_on = (x < t.hv) && (y < t.vv);
    e.frame_tick = e.p_tick && (x == ht - 1) && (y == vt - 1);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at n=%0d t=%0t", name, act, req, n, $time);
    end
  endtask

  task automatic compareDut(input string tag, input timing_t t, input int cyc,
                            input logic hs, input logic vs, input logic von,
                            input logic pt, input logic ft,
                            input logic [9:0] x, input logic [9:0] y);
    exp_t e;
    e = model(t, cyc);
    checkOutput({tag, "_x"}, int'(x), int'(e.x));
    checkOutput({tag, "_y"}, int'(y), int'(e.y));
    checkOutput({tag, "_hsync"}, int'(hs), int'(e.hsync));
    checkOutput({tag, "_vsync"}, int'(vs), int'(e.vsync));
    checkOutput({tag, "_video_on"}, int'(von), int'(e.video_on));
    checkOutput({tag, "_p_tick"}, int'(pt), int'(e.p_tick));
    checkOutput({tag, "_frame_tick"}, int'(ft), int'(e.frame_tick));
  endtask

  always @(negedge clk_d) begin
    compareDut("d0", T0, n, d0_hsync, d0_vsync, d0_von, d0_pt, d0_ft, d0_x, d0_y);
    compareDut("d1", T1, n, d1_hsync, d1_vsync, d1_von, d1_pt, d1_ft, d1_x, d1_y);
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_d0_x"}, int'(d0_x), 0);
    checkOutput({tag, "_d0_y"}, int'(d0_y), 0);
    checkOutput({tag, "_d0_hsync"}, int'(d0_hsync), 1);
    checkOutput({tag, "_d0_vsync"}, int'(d0_vsync), 1);
    checkOutput({tag, "_d0_video_on"}, int'(d0_von), 1);
    checkOutput({tag, "_d0_frame_tick"}, int'(d0_ft), 0);
    checkOutput({tag, "_d1_x"}, int'(d1_x), 0);
    checkOutput({tag, "_d1_y"}, int'(d1_y), 0);
    checkOutput({tag, "_d1_hsync"}, int'(d1_hsync), 1);
  endtask

  // Reset asserted at a random point between clock edges, held a few cycles.
  task automatic applyStimulus(input int run_cycles);
    int off;
    repeat (run_cycles) @(negedge clk_d);
    off = int'($urandom_range(1, 8));
    if (off >= 5) off++;
    #(off);
    reset = 1'b1;
    #1;
    checkResetValues("rand_rst");
    repeat (int'($urandom_range(1, 4))) @(negedge clk_d);
    reset = 1'b0;
  endtask

  int h0_low = 0, v1_low = 0, von1 = 0, ft1 = 0, ft_k = -1, pt_cnt = 0;
  bit found;

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk_d);
    checkResetValues("por");
    reset = 1'b0;

    for (int k = 0; k <= FRAME1 * DIV + 2; k++) begin
      if (k == 0) begin
        checkOutput("d0_first_x", int'(d0_x), 0);
        checkOutput("d0_first_video_on", int'(d0_von), 1);
      end
      if (k < 40 && d0_pt) pt_cnt++;
      if (k == 639 * DIV) begin
        checkOutput("d0_x_639", int'(d0_x), 639);
        checkOutput("d0_von_639", int'(d0_von), 1);
      end
      if (k == 640 * DIV) begin
        checkOutput("d0_x_640", int'(d0_x), 640);
        checkOutput("d0_von_640", int'(d0_von), 0);
      end
      if (k == 800 * DIV - 1) begin
        checkOutput("d0_line_end_x", int'(d0_x), 799);
        checkOutput("d0_line_end_y", int'(d0_y), 0);
      end
      if (k == 800 * DIV) begin
        checkOutput("d0_wrap_x", int'(d0_x), 0);
        checkOutput("d0_wrap_y", int'(d0_y), 1);
      end
      if (k < 800 * DIV && !d0_hsync) begin
        if (h0_low == 0) checkOutput("d0_hsync_start_x", int'(d0_x), 656);
        h0_low++;
      end
      if (k < FRAME1 * DIV) begin
        if (!d1_vsync) begin
          if (v1_low == 0) begin
            checkOutput("d1_vsync_start_x", int'(d1_x), 0);
            checkOutput("d1_vsync_start_y", int'(d1_y), 51);
          end
          v1_low++;
        end
        if (d1_von) von1++;
        if (d1_ft) begin
          ft1++;
          ft_k = k;
          checkOutput("d1_ft_x", int'(d1_x), 79);
          checkOutput("d1_ft_y", int'(d1_y), 57);
        end
      end
      if (ft_k >= 0 && k == ft_k + 1) begin
        checkOutput("d1_after_ft_x", int'(d1_x), 0);
        checkOutput("d1_after_ft_y", int'(d1_y), 0);
      end
      @(negedge clk_d);
    end

    checkOutput("d0_p_tick_count_40", pt_cnt, 40 / DIV);
    checkOutput("d0_hsync_low_cycles", h0_low, 96 * DIV);
    checkOutput("d1_vsync_low_cycles", v1_low, 2 * 80 * DIV);
    checkOutput("d1_video_on_cycles", von1, 64 * 48 * DIV);
    checkOutput("d1_frame_tick_count", ft1, 1);
    checkOutput("d1_frame_len", ft_k, FRAME1 * DIV - 1);

    // Reset in the middle of an hsync pulse must release hsync immediately.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME1 * DIV && !found; i++) begin
      if (d1_x == 10'd70 && !d1_hsync) found = 1'b1;
      else @(negedge clk_d);
    end
    checkOutput("d1_wait_hsync_low", int'(found), 1);
    if (found) begin
      #2;
      reset = 1'b1;
      #1;
      checkResetValues("mid_sync");
      repeat (2) @(negedge clk_d);
      reset = 1'b0;
      repeat (DIV) @(negedge clk_d);
      checkOutput("d1_resume_x", int'(d1_x), 1);
      checkOutput("d1_resume_y", int'(d1_y), 0);
      checkOutput("d0_resume_x", int'(d0_x), 1);
    end

    for (int r = 0; r < 6; r++) begin
      applyStimulus(int'($urandom_range(100, 3000)));
    end
    repeat (FRAME1 + 200) @(negedge clk_d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
